// File: rtl/alu_arbiter_pkg.sv
// Shared types and helpers for the ALU arbiter: operand width default,
// RV32 funct3/funct7 encodings and the requester-ID width function.
package alu_arbiter_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } funct7_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response signals of the ALU arbiter.
// The arbiter uses the slave view; requesters/ALU/consumer use the master view.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*3-1:0]    req_funct3;
  logic [NUM_REQ*7-1:0]    req_funct7;
  logic [NUM_REQ*XLEN-1:0] req_op1;
  logic [NUM_REQ*XLEN-1:0] req_op2;
  logic [2:0]              alu_funct3;
  logic [6:0]              alu_funct7;
  logic [XLEN-1:0]         alu_operand1;
  logic [XLEN-1:0]         alu_operand2;
  logic [XLEN-1:0]         alu_result;
  logic                    alu_zero;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [XLEN-1:0]         rsp_data;
  logic                    rsp_zero;

  modport slave (
    input  req_valid, req_funct3, req_funct7, req_op1, req_op2,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_funct3, alu_funct7, alu_operand1, alu_operand2,
    output rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport master (
    output req_valid, req_funct3, req_funct7, req_op1, req_op2,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_funct3, alu_funct7, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo NUM_REQ, reported as one-hot grant plus encoded index.
module alu_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_sum;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    // Rotate so bit 0 is the current priority holder, then take the lowest set bit.
    w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
    if (i_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!o_any && w_rot[k]) begin
          o_any = 1'b1;
          w_sum = int'(i_ptr) + k;
        end
      end
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      if (o_any) begin
        o_idx   = ID_W'(w_sum);
        o_grant = NUM_REQ'(1) << o_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// operand steering and a single registered response slot with backpressure.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic        CLK,
  input  logic        RST_N,
  alu_arbiter_if.slave bus
);

  logic               r_rsp_valid;
  logic [XLEN-1:0]    r_rsp_data;
  logic               r_rsp_zero;
  logic [ID_W-1:0]    r_rsp_id;
  logic [ID_W-1:0]    r_rr_ptr;

  logic               w_accept;
  logic               w_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;

  // The slot can take a new result when empty or when it retires this cycle.
  assign w_accept = !r_rsp_valid || bus.rsp_ready;

  alu_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .i_req  (bus.req_valid),
    .i_ptr  (r_rr_ptr),
    .i_en   (w_accept && RST_N),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign bus.req_ready = w_grant;

  always_comb begin
    bus.alu_funct3   = '0;
    bus.alu_funct7   = '0;
    bus.alu_operand1 = '0;
    bus.alu_operand2 = '0;
    if (w_any) begin
      bus.alu_funct3   = bus.req_funct3[int'(w_idx)*3 +: 3];
      bus.alu_funct7   = bus.req_funct7[int'(w_idx)*7 +: 7];
      bus.alu_operand1 = bus.req_op1[int'(w_idx)*XLEN +: XLEN];
      bus.alu_operand2 = bus.req_op2[int'(w_idx)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      if (w_any) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= bus.alu_result;
        r_rsp_zero  <= bus.alu_zero;
        r_rsp_id    <= w_idx;
        r_rr_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end else begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_id    = r_rsp_id;

endmodule
